// File: rtl/wifi_tx_frame_serializer_if.sv
// wifi_tx_frame_serializer_if: FIFO read handshake between the serializer (master) and the TX word FIFO (slave)
interface wifi_tx_frame_serializer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  word_rd;
  logic [DATA_WIDTH-1:0] word_data;
  logic                  word_valid;
  modport master (output word_rd, input word_data, input word_valid);
  modport slave (input word_rd, output word_data, output word_valid);
endinterface

// File: rtl/wifi_tx_frame_serializer.sv
// wifi_tx_frame_serializer: gapless word-to-bit frame serializer with one-word prefetch; WIFI_SER_LSB_FIRST_EN selects LSB-first order
module wifi_tx_frame_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       start,
  input  logic [LEN_WIDTH-1:0]       frame_bits,
  wifi_tx_frame_serializer_if.master fifo,
  output logic                       bit_out,
  output logic                       bit_valid,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       underrun
);
  localparam int WLW = $clog2(DATA_WIDTH + 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [LEN_WIDTH-1:0]  bits_left_q, bits_left_d, bits_next;
  logic [WLW-1:0]        word_left_q, word_left_d, cur_left, left_next, load_left, refill_left;
  logic [DATA_WIDTH-1:0] sh_q, sh_d, hold_q, hold_d, cur_data, shifted;
  logic                  hold_full_q, hold_full_d, rd_pend_q, rd_pend_d;
  logic                  word_rd_q, word_rd_d, bit_out_q, bit_out_d, bit_valid_q, bit_valid_d;
  logic                  busy_q, busy_d, frame_done_q, frame_done_d, underrun_q, underrun_d;
  logic                  vld, load, fire, cur_bit;

  assign fifo.word_rd = word_rd_q;
  assign bit_out      = bit_out_q;
  assign bit_valid    = bit_valid_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;
  assign underrun     = underrun_q;

  // Pick the word being shifted this cycle (fresh FIFO word on load, else the shifter) and its next-bit bookkeeping
  always_comb begin
    vld         = fifo.word_valid & rd_pend_q;
    load        = (state_q == FETCH) & vld;
    fire        = enable & (load | (state_q == SHIFT));
    bits_next   = bits_left_q - LEN_WIDTH'(1);
    load_left   = (32'(bits_left_q) > DATA_WIDTH) ? WLW'(DATA_WIDTH) : WLW'(bits_left_q);
    refill_left = (32'(bits_next) > DATA_WIDTH) ? WLW'(DATA_WIDTH) : WLW'(bits_next);
    cur_data    = load ? fifo.word_data : sh_q;
    cur_left    = load ? load_left : word_left_q;
    left_next   = cur_left - WLW'(1);
`ifdef WIFI_SER_LSB_FIRST_EN
    cur_bit     = cur_data[0];
    shifted     = cur_data >> 1;
`else
    cur_bit     = cur_data[DATA_WIDTH-1];
    shifted     = cur_data << 1;
`endif
  end

  // Frame sequencing: start/fetch/shift/done, prefetch into the hold register and underrun detection
  always_comb begin
    state_d      = state_q;
    bits_left_d  = bits_left_q;
    word_left_d  = word_left_q;
    sh_d         = sh_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    rd_pend_d    = rd_pend_q & ~fifo.word_valid;
    word_rd_d    = 1'b0;
    bit_out_d    = bit_out_q;
    bit_valid_d  = 1'b0;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    underrun_d   = underrun_q;
    if (state_q == IDLE && start && !frame_done_q) begin
      bits_left_d = frame_bits;
      underrun_d  = 1'b0;
      busy_d      = 1'b1;
      state_d     = (frame_bits == '0) ? DONE : FETCH;
      word_rd_d   = (frame_bits != '0);
      rd_pend_d   = (frame_bits != '0);
    end
    if (state_q == DONE) begin
      frame_done_d = 1'b1;
      busy_d       = 1'b0;
      state_d      = IDLE;
    end
    if (load) begin
      sh_d        = fifo.word_data;
      word_left_d = load_left;
      state_d     = SHIFT;
      if (32'(bits_left_q) > DATA_WIDTH) begin
        word_rd_d = 1'b1;
        rd_pend_d = 1'b1;
      end
    end
    if (state_q == SHIFT && vld) begin
      hold_d      = fifo.word_data;
      hold_full_d = 1'b1;
    end
    if (fire) begin
      bit_out_d   = cur_bit;
      bit_valid_d = 1'b1;
      bits_left_d = bits_next;
      word_left_d = left_next;
      sh_d        = shifted;
      if (left_next == '0) begin
        if (bits_next == '0) begin
          state_d = DONE;
        end else if (hold_full_q || (state_q == SHIFT && vld)) begin
          sh_d        = hold_full_q ? hold_q : fifo.word_data;
          hold_full_d = 1'b0;
          word_left_d = refill_left;
          if (32'(bits_next) > DATA_WIDTH) begin
            word_rd_d = 1'b1;
            rd_pend_d = 1'b1;
          end
        end else begin
          underrun_d = 1'b1;
          state_d    = FETCH;
        end
      end
    end
  end

  // State and output registers; asynchronous reset aborts any frame in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      bits_left_q  <= '0;
      word_left_q  <= '0;
      sh_q         <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      rd_pend_q    <= 1'b0;
      word_rd_q    <= 1'b0;
      bit_out_q    <= 1'b0;
      bit_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bits_left_q  <= bits_left_d;
      word_left_q  <= word_left_d;
      sh_q         <= sh_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      rd_pend_q    <= rd_pend_d;
      word_rd_q    <= word_rd_d;
      bit_out_q    <= bit_out_d;
      bit_valid_q  <= bit_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
    end
  end
endmodule

// File: tb/tb_wifi_tx_frame_serializer.sv
// tb_wifi_tx_frame_serializer: scoreboard bench with a latency-programmable FIFO model
module tb_wifi_tx_frame_serializer;
  logic        clk = 1'b0;
  logic        reset, enable, start;
  logic [15:0] frame_bits;
  logic        bit_out, bit_valid, busy, frame_done, underrun;
  int          n_vec = 0;
  int          n_bad = 0;
  bit          exp_q[$];

  wifi_tx_frame_serializer_if #(.DATA_WIDTH(32)) fif();

  wifi_tx_frame_serializer #(.DATA_WIDTH(32), .LEN_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .frame_bits(frame_bits),
    .fifo(fif), .bit_out(bit_out), .bit_valid(bit_valid), .busy(busy),
    .frame_done(frame_done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_frame(input int nb, input logic [31:0] w0, input logic [31:0] w1,
                           input int lat, input bit tog, input int abort, input bit exp_und);
    logic [31:0] wq[$];
    logic [31:0] w;
    int cnt, nrd, nseen, first, last, done_cyc;
    bit und_seen, prev_en, prev_bit, aborted;
    wq = {w0, w1};
    cnt = 0; nrd = 0; nseen = 0; first = -1; last = -1; done_cyc = -1;
    und_seen = 0; prev_en = 1; prev_bit = 0; aborted = 0;
    exp_q.delete();
    for (int i = 0; i < nb; i++) begin
      w = (i < 32) ? w0 : w1;
`ifdef WIFI_SER_LSB_FIRST_EN
      exp_q.push_back(w[i % 32]);
`else
      exp_q.push_back(w[31 - (i % 32)]);
`endif
    end
    @(negedge clk);
    start = 1; frame_bits = 16'(nb); enable = 1;
    @(negedge clk);
    start = 0;
    check("busy_up", busy, 1);
    check("rd_up", fif.word_rd, nb != 0);
    check("und_clr", underrun, 0);
    for (int c = 1; c < 400; c++) begin
      if (bit_valid) begin
        if (exp_q.size() == 0) check("extra_bit", 1, 0);
        else check("bit", bit_out, exp_q.pop_front());
        if (tog) check("en_gate", prev_en, 1);
        nseen++;
        if (first < 0) first = c;
        last = c;
        prev_bit = bit_out;
      end else if (tog && nseen > 0) begin
        check("hold", bit_out, prev_bit);
      end
      if (underrun && !und_seen) begin
        und_seen = 1;
        check("und_at", nseen, 32);
      end
      if (frame_done) begin
        done_cyc = c;
        check("busy_dn", busy, 0);
        break;
      end
      if (abort > 0 && nseen == abort) begin
        reset = 0;
        #1;
        check("rst_out", {26'd0, fif.word_rd, bit_out, bit_valid, busy, frame_done, underrun}, 0);
        @(negedge clk);
        reset = 1;
        aborted = 1;
        break;
      end
      fif.word_valid = 0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0 && wq.size() > 0) begin
          fif.word_valid = 1;
          fif.word_data = wq.pop_front();
        end
      end
      if (fif.word_rd) begin
        nrd++;
        cnt = lat;
      end
      enable = tog ? c[0] : 1'b1;
      prev_en = enable;
      @(negedge clk);
    end
    fif.word_valid = 0;
    if (aborted) begin
      check("rst_done", frame_done, 0);
      return;
    end
    check("done_seen", done_cyc > 0, 1);
    check("nbits", nseen, nb);
    check("left", exp_q.size(), 0);
    check("reads", nrd, (nb + 31) / 32);
    check("und_end", underrun, exp_und);
    if (nb == 0) check("done_lat0", done_cyc, 2);
    else check("done_lat", done_cyc - last, 1);
    if (nb > 0 && !exp_und) check("span", last - first + 1, tog ? 2 * nb - 1 : nb);
  endtask

  initial begin
    reset = 0; start = 0; enable = 0; frame_bits = 0;
    fif.word_valid = 0; fif.word_data = 0;
    repeat (3) @(negedge clk);
    check("rst_vals", {26'd0, fif.word_rd, bit_out, bit_valid, busy, frame_done, underrun}, 0);
    reset = 1;
    run_frame(64, 32'hA5A5_0001, 32'h8000_00FF, 1, 0, 0, 0);
    run_frame(40, 32'hFFFF_FFFF, 32'hF000_0000, 1, 0, 0, 0);
    run_frame(0, 32'h0, 32'h0, 1, 0, 0, 0);
    run_frame(32, 32'h5A3C_96E1, 32'h0, 1, 1, 0, 0);
    run_frame(64, 32'h1234_5678, 32'h9ABC_DEF0, 40, 0, 0, 1);
    run_frame(33, 32'hC3C3_0F0F, 32'h8000_0000, 1, 0, 0, 0);
    run_frame(64, 32'hDEAD_BEEF, 32'h0F1E_2D3C, 20, 0, 0, 0);
    run_frame(64, 32'hCAFE_F00D, 32'h1357_9BDF, 1, 0, 10, 0);
    run_frame(64, 32'hCAFE_F00D, 32'h1357_9BDF, 1, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
